// File: rtl/mem_read_prefetch.sv
// Burst read prefetcher: streams a word range from a memory slave
// into a first-word-fall-through FIFO for a downstream consumer.
module mem_read_prefetch #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [21:0] start_address,
  input  logic [15:0] word_count,
  input  logic        abort,
  output logic        busy,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [21:0] mem_address,
  output logic        mem_request,
  output logic        mem_write_enable,
  output logic [15:0] mem_data_write,
  output logic        mem_last4,
  input  logic        mem_ready,
  input  logic [15:0] mem_data_read
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   rem_q, rem_d;
  logic [21:0]   naddr_q, naddr_d;
  logic [21:0]   maddr_q, maddr_d;
  logic          got_q, got_d;
  logic [15:0]   fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;

  assign mem_request      = (state_q == S_REQ);
  assign mem_address      = maddr_q;
  assign mem_write_enable = 1'b0;
  assign mem_data_write   = '0;
  assign busy             = (state_q != S_IDLE);
  assign mem_last4        = busy && (rem_q <= 16'd4);

  assign push      = mem_request && mem_ready && !abort;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_q[rptr_q] : '0;
  assign cnt_d     = cnt_q + {{AW{1'b0}}, push}
                   - {{AW{1'b0}}, pop};

  // Next state: burst sequencing, counters and address tracking
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q - {15'd0, push};
    naddr_d = naddr_q + {21'd0, push};
    maddr_d = maddr_q;
    got_d   = got_q | push;
    unique case (state_q)
      S_IDLE: begin
        if (start && (word_count != '0)) begin
          rem_d   = word_count;
          naddr_d = start_address;
          got_d   = 1'b0;
          if (cnt_d != DEPTH_C) begin
            state_d = S_REQ;
            maddr_d = start_address;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_REQ: begin
        if (rem_d == '0)
          state_d = S_IDLE;
        else if (cnt_d == DEPTH_C)
          state_d = S_GAP;
        else if (!mem_ready && got_q)
          state_d = S_GAP;
      end
      S_GAP: begin
        if (rem_q == '0) begin
          state_d = S_IDLE;
        end else if (cnt_q != DEPTH_C) begin
          state_d = S_REQ;
          maddr_d = naddr_q;
          got_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      rem_d   = '0;
      got_d   = 1'b0;
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      naddr_q <= '0;
      maddr_q <= '0;
      got_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      naddr_q <= naddr_d;
      maddr_q <= maddr_d;
      got_q   <= got_d;
    end
  end

  // FIFO storage, pointers and occupancy; abort flushes everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (abort) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= mem_data_read;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule
